// File: rtl/vram32_port_arbiter_pkg.sv
// Shared GPU definitions for the VRAM32 port arbiter: owner tags and RAM geometry.
package vram32_port_arbiter_pkg;

  localparam int unsigned VRAM32_ADDR_W = 14;
  localparam int unsigned VRAM32_DATA_W = 32;

  // Which requester owns the read data returning from the RAM this cycle.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnBgw  = 2'd1,
    OwnSpr  = 2'd2,
    OwnCpu  = 2'd3
  } owner_e;

  // Grant vector bit order: [0] bgw, [1] spr, [2] cpu.
  function automatic owner_e owner_from_grant(logic [2:0] gnt);
    owner_e own;
    unique case (gnt)
      3'b001:  own = OwnBgw;
      3'b010:  own = OwnSpr;
      3'b100:  own = OwnCpu;
      default: own = OwnNone;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/vram32_port_arbiter_prio_arbiter3.sv
// Three-input fixed-priority arbiter. Input 0 always wins; the boost input swaps
// the relative order of inputs 1 and 2.
module prio_arbiter3 (
  input  logic [2:0] req_i,
  input  logic       boost_i,
  output logic [2:0] gnt_o
);

  // One-hot (or zero) grant from the priority chain.
  always_comb begin
    gnt_o = 3'b000;
    if (req_i[0]) begin
      gnt_o = 3'b001;
    end else if (boost_i && req_i[2]) begin
      gnt_o = 3'b100;
    end else if (req_i[1]) begin
      gnt_o = 3'b010;
    end else if (req_i[2]) begin
      gnt_o = 3'b100;
    end
  end

endmodule

// File: rtl/vram32_port_arbiter.sv
// Shares the single VRAM32 port between BGW fetch, sprite fetch and the CPU bridge.
// Grants are combinational; read data returns one cycle later, steered by an owner tag.
module vram32_port_arbiter
  import vram32_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = VRAM32_ADDR_W,
  parameter int unsigned DATA_W       = VRAM32_DATA_W,
  parameter int unsigned CPU_MAX_WAIT = 64,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic              vga_clk,
  input  logic              reset,

  input  logic              bgw_req,
  input  logic [ADDR_W-1:0] bgw_addr,
  output logic              bgw_grant,
  output logic              bgw_valid,
  output logic [DATA_W-1:0] bgw_q,

  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_grant,
  output logic              spr_valid,
  output logic [DATA_W-1:0] spr_q,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_q,

  output logic [ADDR_W-1:0] vram32_addr,
  output logic              vram32_we,
  output logic [DATA_W-1:0] vram32_d,
  input  logic [DATA_W-1:0] vram32_q,

  output logic              spr_denied
);

  localparam logic [WAIT_W-1:0] WaitThresh = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WaitSat    = {WAIT_W{1'b1}};

  owner_e            owner_q, owner_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              cpu_inflight_q, cpu_inflight_d;
  logic              spr_denied_q, spr_denied_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              cpu_eligible;
  logic              boost;
  logic [2:0]        req;
  logic [2:0]        gnt_raw;
  logic [2:0]        gnt;

  // The inflight flag keeps a request that is still held during its ack cycle
  // from being served a second time.
  assign cpu_eligible = cpu_req & ~cpu_inflight_q;
  assign boost        = cpu_eligible & (wait_cnt_q >= WaitThresh);
  assign req          = {cpu_eligible, spr_req, bgw_req};

  prio_arbiter3 u_prio (
    .req_i   (req),
    .boost_i (boost),
    .gnt_o   (gnt_raw)
  );

  // No grant is ever issued while reset is asserted.
  assign gnt = reset ? 3'b000 : gnt_raw;

  assign bgw_grant = gnt[0];
  assign spr_grant = gnt[1];

  // Port address mux; holds the last address when idle so the RAM inputs stay quiet.
  always_comb begin
    addr_d = addr_q;
    if (reset) begin
      addr_d = '0;
    end else if (gnt[0]) begin
      addr_d = bgw_addr;
    end else if (gnt[1]) begin
      addr_d = spr_addr;
    end else if (gnt[2]) begin
      addr_d = cpu_addr;
    end
  end

  assign vram32_addr = addr_d;
  assign vram32_we   = gnt[2] & cpu_we;
  assign vram32_d    = cpu_data;

  // Next owner tag, inflight flag and sprite-refusal flag.
  always_comb begin
    owner_d        = owner_from_grant(gnt);
    cpu_inflight_d = gnt[2];
    spr_denied_d   = spr_req & ~gnt[1];
  end

  // CPU wait counter: counts denied eligible cycles, saturating, cleared on
  // service or when the CPU withdraws.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt[2] || !cpu_req) begin
      wait_cnt_d = '0;
    end else if (cpu_eligible && (wait_cnt_q != WaitSat)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      owner_q        <= OwnNone;
      wait_cnt_q     <= '0;
      cpu_inflight_q <= 1'b0;
      spr_denied_q   <= 1'b0;
      addr_q         <= '0;
    end else begin
      owner_q        <= owner_d;
      wait_cnt_q     <= wait_cnt_d;
      cpu_inflight_q <= cpu_inflight_d;
      spr_denied_q   <= spr_denied_d;
      addr_q         <= addr_d;
    end
  end

  // Strobes decode the registered owner; reset suppresses any strobe still pending
  // from a grant made just before it.
  assign bgw_valid  = ~reset & (owner_q == OwnBgw);
  assign spr_valid  = ~reset & (owner_q == OwnSpr);
  assign cpu_ack    = ~reset & (owner_q == OwnCpu);
  assign spr_denied = ~reset & spr_denied_q;

  assign bgw_q = vram32_q;
  assign spr_q = vram32_q;
  assign cpu_q = vram32_q;

endmodule

// File: tb/tb_vram32_port_arbiter.sv
// Self-checking bench for vram32_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level reference model.
module tb_vram32_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          vga_clk;
  logic          reset;
  logic          bgw_req, spr_req, cpu_req, cpu_we;
  logic [AW-1:0] bgw_addr, spr_addr, cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          bgw_grant, bgw_valid, spr_grant, spr_valid, cpu_ack, spr_denied;
  logic [DW-1:0] bgw_q, spr_q, cpu_q;
  logic [AW-1:0] vram32_addr;
  logic          vram32_we;
  logic [DW-1:0] vram32_d, vram32_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;

  int checks = 0;
  int errors = 0;

  vram32_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .CPU_MAX_WAIT (MW),
    .WAIT_W       (8)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .bgw_req     (bgw_req),
    .bgw_addr    (bgw_addr),
    .bgw_grant   (bgw_grant),
    .bgw_valid   (bgw_valid),
    .bgw_q       (bgw_q),
    .spr_req     (spr_req),
    .spr_addr    (spr_addr),
    .spr_grant   (spr_grant),
    .spr_valid   (spr_valid),
    .spr_q       (spr_q),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_ack     (cpu_ack),
    .cpu_q       (cpu_q),
    .vram32_addr (vram32_addr),
    .vram32_we   (vram32_we),
    .vram32_d    (vram32_d),
    .vram32_q    (vram32_q),
    .spr_denied  (spr_denied)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  assign vram32_q = ram_q;

  // Block RAM with 1-cycle read latency, read-first on a write.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE0000 + 32'(i);
    ram_q = '0;
    forever begin
      @(posedge vga_clk);
      ram_q <= mem[vram32_addr];
      if (vram32_we) mem[vram32_addr] <= vram32_d;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference model: winner chosen from the priority rules each cycle; the
  // winner's expected data is captured from the RAM image and checked next cycle.
  int            m_own = 0;      // 0 none, 1 bgw, 2 spr, 3 cpu
  bit            m_own_write = 0;
  logic [DW-1:0] m_data = '0;
  int            m_wait = 0;
  bit            m_inflight = 0;
  bit            m_denied = 0;
  logic [AW-1:0] m_addr = '0;

  always @(negedge vga_clk) begin : model
    int            win;
    bit            elig, boost;
    logic [AW-1:0] ea;
    if (reset) begin
      chk1("rst_bgw_grant", bgw_grant, 1'b0);
      chk1("rst_spr_grant", spr_grant, 1'b0);
      chk1("rst_we", vram32_we, 1'b0);
      chk("rst_addr", 32'(vram32_addr), 32'd0);
      chk1("rst_bgw_valid", bgw_valid, 1'b0);
      chk1("rst_spr_valid", spr_valid, 1'b0);
      chk1("rst_cpu_ack", cpu_ack, 1'b0);
      chk1("rst_spr_denied", spr_denied, 1'b0);
      m_own = 0; m_wait = 0; m_inflight = 0; m_denied = 0; m_addr = '0;
    end else begin
      elig  = cpu_req && !m_inflight;
      boost = elig && (m_wait >= MW);
      if (bgw_req)      win = 1;
      else if (boost)   win = 3;
      else if (spr_req) win = 2;
      else if (elig)    win = 3;
      else              win = 0;
      ea = (win == 1) ? bgw_addr : (win == 2) ? spr_addr : (win == 3) ? cpu_addr : m_addr;

      chk1("bgw_grant", bgw_grant, win == 1);
      chk1("spr_grant", spr_grant, win == 2);
      chk1("vram32_we", vram32_we, (win == 3) && cpu_we);
      chk("vram32_addr", 32'(vram32_addr), 32'(ea));
      if (win == 3 && cpu_we) chk("vram32_d", vram32_d, cpu_data);
      chk1("bgw_valid", bgw_valid, m_own == 1);
      chk1("spr_valid", spr_valid, m_own == 2);
      chk1("cpu_ack", cpu_ack, m_own == 3);
      chk1("spr_denied", spr_denied, m_denied);
      if (m_own == 1) chk("bgw_q", bgw_q, m_data);
      if (m_own == 2) chk("spr_q", spr_q, m_data);
      if (m_own == 3 && !m_own_write) chk("cpu_q", cpu_q, m_data);

      if (win != 0) m_data = mem[ea];
      m_own_write = (win == 3) && cpu_we;
      m_own       = win;
      m_denied    = spr_req && (win != 2);
      if (win == 3 || !cpu_req) m_wait = 0;
      else if (elig && m_wait < 255) m_wait = m_wait + 1;
      m_inflight  = (win == 3);
      m_addr      = ea;
    end
  end

  task automatic nxt();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle_reqs();
    bgw_req = 0; spr_req = 0; cpu_req = 0; cpu_we = 0;
  endtask

  initial begin : main
    bit got_ack;
    // 1: reset held with every requester active, released at cycle 5
    reset = 1; bgw_req = 1; bgw_addr = 14'h0010; spr_req = 1; spr_addr = 14'h0020;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0030; cpu_data = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge vga_clk);
      chk1("t1_no_grant", bgw_grant, 1'b0);
      chk1("t1_no_valid", bgw_valid, 1'b0);
      nxt();
    end
    reset = 0;
    @(negedge vga_clk);
    chk1("t1_bgw_grant", bgw_grant, 1'b1);
    chk1("t1_spr_grant", spr_grant, 1'b0);
    nxt(); bgw_req = 0; spr_req = 0;
    @(negedge vga_clk);
    chk1("t1_bgw_valid", bgw_valid, 1'b1);
    chk("t1_bgw_q", bgw_q, 32'hC0DE0010);
    chk("t1_cpu_addr", 32'(vram32_addr), 32'h0030);
    nxt();
    @(negedge vga_clk);
    chk1("t1_cpu_ack", cpu_ack, 1'b1);
    chk("t1_cpu_q", cpu_q, 32'hC0DE0030);

    // 2: BGW and sprite collide; sprite retries
    nxt(); idle_reqs(); bgw_req = 1; bgw_addr = 14'h0010; spr_req = 1; spr_addr = 14'h0020;
    @(negedge vga_clk);
    chk1("t2_bgw_grant", bgw_grant, 1'b1);
    chk1("t2_spr_grant", spr_grant, 1'b0);
    nxt(); bgw_req = 0;
    @(negedge vga_clk);
    chk1("t2_spr_denied", spr_denied, 1'b1);
    chk1("t2_spr_retry_grant", spr_grant, 1'b1);
    nxt(); spr_req = 0;
    @(negedge vga_clk);
    chk1("t2_spr_valid", spr_valid, 1'b1);
    chk("t2_spr_q", spr_q, 32'hC0DE0020);
    chk1("t2_spr_denied_clr", spr_denied, 1'b0);

    // 3/4: CPU write held across its ack, then a read-back
    nxt(); cpu_req = 1; cpu_we = 1; cpu_addr = 14'h1234; cpu_data = 32'hDEADBEEF;
    @(negedge vga_clk);
    chk1("t3_we", vram32_we, 1'b1);
    chk("t3_addr", 32'(vram32_addr), 32'h1234);
    nxt();
    @(negedge vga_clk);
    chk1("t4_we_once", vram32_we, 1'b0);
    chk1("t3_write_ack", cpu_ack, 1'b1);
    nxt(); cpu_we = 0;
    @(negedge vga_clk);
    chk1("t4_single_ack", cpu_ack, 1'b0);
    nxt();
    @(negedge vga_clk);
    chk1("t3_read_ack", cpu_ack, 1'b1);
    chk("t3_read_q", cpu_q, 32'hDEADBEEF);

    // 5: sprite streaming; CPU boosted on its 5th cycle, twice in a row
    nxt(); idle_reqs(); spr_req = 1; spr_addr = 14'h0020; cpu_req = 1; cpu_addr = 14'h0005;
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 5; i++) begin
        @(negedge vga_clk);
        chk1("t5_spr_grant", spr_grant, i < 5);
        chk("t5_addr", 32'(vram32_addr), (i < 5) ? 32'h0020 : 32'(cpu_addr));
        if (i < 5) nxt();
      end
      nxt();
      @(negedge vga_clk);
      chk1("t5_cpu_ack", cpu_ack, 1'b1);
      chk("t5_cpu_q", cpu_q, 32'hC0DE0000 + 32'(cpu_addr));
      chk1("t5_spr_in_ack", spr_grant, 1'b1);
      nxt(); cpu_addr = 14'h0006;
    end
    idle_reqs();

    // 6: reset in the ack cycle drops the ack; the held request is re-served
    nxt(); cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0007;
    @(negedge vga_clk);
    chk("t6_grant_addr", 32'(vram32_addr), 32'h0007);
    nxt(); reset = 1;
    @(negedge vga_clk);
    chk1("t6_no_ack", cpu_ack, 1'b0);
    nxt(); reset = 0;
    @(negedge vga_clk);
    chk("t6_regrant_addr", 32'(vram32_addr), 32'h0007);
    chk1("t6_no_ack2", cpu_ack, 1'b0);
    nxt();
    @(negedge vga_clk);
    chk1("t6_ack", cpu_ack, 1'b1);
    chk("t6_cpu_q", cpu_q, 32'hC0DE0007);
    nxt(); idle_reqs();

    // Randomized traffic; the CPU obeys its hold-until-ack handshake
    for (int n = 0; n < 3000; n++) begin
      @(negedge vga_clk);
      got_ack = cpu_ack;
      nxt();
      reset    = ($urandom_range(0, 199) == 0);
      bgw_req  = ($urandom_range(0, 2) == 0);
      bgw_addr = 14'($urandom_range(0, 15));
      spr_req  = ($urandom_range(0, 1) == 0);
      spr_addr = 14'($urandom_range(0, 15));
      if (!cpu_req || got_ack) begin
        cpu_req  = ($urandom_range(0, 2) == 0);
        cpu_we   = ($urandom_range(0, 1) == 0);
        cpu_addr = 14'($urandom_range(0, 15));
        cpu_data = $urandom;
      end
    end
    reset = 0; idle_reqs();
    nxt(); nxt();
    @(negedge vga_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram32_port_arbiter.md
Name: vram32_port_arbiter

Overview:
- Shares one VRAM32 read/write port between three requesters: BGW renderer fetch (highest priority), sprite renderer fetch, and CPU bus access.
- Replaces the duplicated VRAM32 copy that currently feeds the sprite renderer.
- Sits in the GPU clock domain, between the renderers and CPU bridge on one side and the VRAM32 block RAM (1-cycle read latency) on the other.
- Fixed priority, with an anti-starvation boost that lets the CPU pre-empt sprite fetches but never BGW.

Parameters:
- ADDR_W, 14, VRAM32 address width.
- DATA_W, 32, VRAM32 data width.
- CPU_MAX_WAIT, 64, number of consecutive denied CPU cycles after which the CPU outranks the sprite requester.
- WAIT_W, 8, width of the CPU wait counter; must satisfy 2^WAIT_W > CPU_MAX_WAIT.

Ports:
- vga_clk  in  1  GPU pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- bgw_req  in  1  BGW fetch request this cycle.
- bgw_addr  in  ADDR_W  BGW fetch address.
- bgw_grant  out  1  combinational; BGW owns the port this cycle.
- bgw_valid  out  1  registered; bgw_q is valid.
- bgw_q  out  DATA_W  read data for BGW.
- spr_req  in  1  sprite fetch request.
- spr_addr  in  ADDR_W  sprite fetch address.
- spr_grant  out  1  combinational grant for the sprite requester.
- spr_valid  out  1  sprite read data valid.
- spr_q  out  DATA_W  read data for the sprite renderer.
- cpu_req  in  1  CPU request; held until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_data  in  DATA_W  CPU write data.
- cpu_ack  out  1  single-cycle completion pulse.
- cpu_q  out  DATA_W  CPU read data, valid with cpu_ack.
- vram32_addr  out  ADDR_W  RAM address.
- vram32_we  out  1  RAM write enable.
- vram32_d  out  DATA_W  RAM write data.
- vram32_q  in  DATA_W  RAM read data, 1 cycle after the address.
- spr_denied  out  1  registered pulse: the sprite requester was refused in the previous cycle.

Behaviour:

Arbitration (combinational, every cycle):
- Default priority: bgw > spr > cpu_eligible.
- Boost: when cpu_eligible is set and wait_cnt >= CPU_MAX_WAIT, priority becomes bgw > cpu > spr.
- cpu_eligible = cpu_req & ~cpu_inflight.
- At most one grant is asserted. With no request, all grants are 0 and vram32_we = 0.

Port mux:
- vram32_addr = address of the granted requester; hold the previous value when idle (no toggling).
- vram32_we = cpu granted & cpu_we.
- vram32_d = cpu_data.

Owner tag:
- 2-bit register: NONE / BGW / SPR / CPU; takes the winner at each clock edge.
- In the cycle after a grant (N+1), exactly one of bgw_valid / spr_valid / cpu_ack pulses high for one cycle.
- bgw_q, spr_q and cpu_q all route vram32_q. Each is meaningful only with its strobe.
- A CPU write also acks in N+1; cpu_q is don't-care on a write.
- Latency: exactly 1 cycle from grant to strobe for every requester.

CPU handshake:
- cpu_req, cpu_we, cpu_addr and cpu_data are stable from assertion until cpu_ack.
- cpu_inflight is set on a CPU grant and cleared on the following edge. This blocks a second grant during the ack cycle, so a held request is never served twice.
- The CPU may raise a new request in the cycle after ack.

Wait counter:
- wait_cnt increments while cpu_eligible and not granted, saturating at its maximum.
- It clears to 0 on a CPU grant or when cpu_req = 0.

Sprite requester:
- BGW is never stalled.
- The sprite requester is not queued: if spr_req is denied it must re-present the request. spr_denied pulses in the next cycle.

Reset (synchronous):
- All grants deasserted during reset.
- Owner = NONE; wait_cnt = 0; cpu_inflight = 0.
- All valid/ack/denied outputs = 0; vram32_we = 0; vram32_addr = 0.
- Reset mid-transaction drops any pending strobe: no ack or valid is emitted for a grant made in the reset cycle. The CPU must re-request.

Boundary conditions:
- All three requesting in one cycle → BGW granted; wait_cnt increments.
- BGW requesting continuously → the CPU may wait indefinitely. Accepted: the renderer guarantees blanking gaps.
- wait_cnt saturates rather than wrapping.

Decomposition:
- Shared gpu package:
  - owner tag encoding (OWN_NONE = 0, OWN_BGW = 1, OWN_SPR = 2, OWN_CPU = 3);
  - VRAM32 address and data width constants.
- One sub-module, prio_arbiter3: a combinational 3-input fixed-priority arbiter with a boost input that swaps the last two priorities.
- The top level holds the owner tag, the wait counter, the inflight flag and the muxes.

Test Plan:
1. Reset with all requests high, released at cycle 5 → cycles 0–4: no grant, no strobe. Cycle 5: bgw_grant. Cycle 6: bgw_valid = 1, bgw_q = RAM[bgw_addr].
2. BGW and sprite request addresses 0x0010 and 0x0020 in the same cycle → BGW granted, spr_denied = 1 next cycle. Sprite retries in the next cycle → granted, then spr_valid with RAM[0x0020].
3. CPU write of 0xDEADBEEF to 0x1234 with no competitors → vram32_we = 1 for exactly one cycle, then cpu_ack one cycle. A CPU read of 0x1234 then acks with cpu_q = 0xDEADBEEF.
4. CPU holds cpu_req high across its ack → exactly one RAM access and one cpu_ack. No grant in the ack cycle.
5. CPU_MAX_WAIT = 4; spr_req is constant, BGW idle, CPU requesting → the CPU is granted on the 5th cycle ahead of the sprite requester. wait_cnt returns to 0.
6. Synchronous reset asserted in the cycle after a CPU grant → no cpu_ack. After reset releases, the held request is re-granted and acked once.
